// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, the PC-source mux and the instruction-memory
// request/ack handshake, and drives the fetch register consumed by decode.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        REG_CLOCK,
  input  logic        REG_RESET,
  input  logic        IF_STALL,
  input  logic [1:0]  PC_SOURCE,
  input  logic [31:0] JALR_TARGET,
  input  logic [31:0] BRANCH_TARGET,
  input  logic [31:0] JAL_TARGET,
  output logic [31:0] IMEM_ADDR,
  output logic        IMEM_REQ,
  input  logic        IMEM_ACK,
  input  logic [31:0] IMEM_DATA,
  output logic [31:0] FR_MEM,
  output logic [31:0] FR_PC,
  output logic [31:0] FR_PC_4,
  output logic        FR_VALID
);

  typedef enum logic [1:0] {FETCH, DISCARD, HELD} state_t;

  state_t      state_p0, state_nxt;
  logic [31:0] pc_p0, pc_nxt;
  logic [31:0] disc_addr_p0, disc_addr_nxt;
  logic [31:0] skid_mem_p0, skid_mem_nxt;
  logic [31:0] skid_pc_p0, skid_pc_nxt;
  logic [31:0] skid_pc_4_p0, skid_pc_4_nxt;
  logic        skid_vld_p0, skid_vld_nxt;
  logic [31:0] fr_mem_p1, fr_mem_nxt;
  logic [31:0] fr_pc_p1, fr_pc_nxt;
  logic [31:0] fr_pc_4_p1, fr_pc_4_nxt;
  logic        vld_p1, vld_nxt;

  logic        redirect;
  logic        ack;
  logic [31:0] target;
  logic [31:0] pc_plus_4;

  // A DISCARD state keeps presenting the abandoned address until its response arrives.
  assign IMEM_REQ  = !REG_RESET && (state_p0 != HELD);
  assign IMEM_ADDR = (state_p0 == DISCARD) ? disc_addr_p0 : pc_p0;
  assign ack       = IMEM_ACK && IMEM_REQ;
  assign redirect  = (PC_SOURCE != 2'd0);
  assign pc_plus_4 = pc_p0 + 32'd4;

  always_comb begin
    target = pc_plus_4;
    case (PC_SOURCE)
      2'd1:    target = JALR_TARGET;
      2'd2:    target = BRANCH_TARGET;
      2'd3:    target = JAL_TARGET;
      default: target = pc_plus_4;
    endcase
  end

  always_comb begin
    state_nxt     = state_p0;
    pc_nxt        = pc_p0;
    disc_addr_nxt = disc_addr_p0;
    skid_mem_nxt  = skid_mem_p0;
    skid_pc_nxt   = skid_pc_p0;
    skid_pc_4_nxt = skid_pc_4_p0;
    skid_vld_nxt  = skid_vld_p0;
    fr_mem_nxt    = fr_mem_p1;
    fr_pc_nxt     = fr_pc_p1;
    fr_pc_4_nxt   = fr_pc_4_p1;
    vld_nxt       = vld_p1;

    if (redirect) begin
      // Redirect outranks stall: the fetch register always takes a bubble.
      pc_nxt       = target;
      fr_mem_nxt   = NOP_INSTR;
      vld_nxt      = 1'b0;
      skid_vld_nxt = 1'b0;
      case (state_p0)
        FETCH: begin
          if (!ack) begin
            state_nxt     = DISCARD;
            disc_addr_nxt = pc_p0;
          end else begin
            state_nxt = FETCH;
          end
        end
        HELD:    state_nxt = FETCH;
        default: state_nxt = DISCARD;
      endcase
    end else begin
      case (state_p0)
        FETCH: begin
          if (ack) begin
            pc_nxt = pc_plus_4;
            if (IF_STALL) begin
              skid_mem_nxt  = IMEM_DATA;
              skid_pc_nxt   = pc_p0;
              skid_pc_4_nxt = pc_plus_4;
              skid_vld_nxt  = 1'b1;
              state_nxt     = HELD;
            end else begin
              fr_mem_nxt  = IMEM_DATA;
              fr_pc_nxt   = pc_p0;
              fr_pc_4_nxt = pc_plus_4;
              vld_nxt     = 1'b1;
            end
          end else if (!IF_STALL) begin
            fr_mem_nxt = NOP_INSTR;
            vld_nxt    = 1'b0;
          end
        end
        HELD: begin
          if (!IF_STALL) begin
            fr_mem_nxt   = skid_mem_p0;
            fr_pc_nxt    = skid_pc_p0;
            fr_pc_4_nxt  = skid_pc_4_p0;
            vld_nxt      = skid_vld_p0;
            skid_vld_nxt = 1'b0;
            state_nxt    = FETCH;
          end
        end
        default: begin
          if (ack) state_nxt = FETCH;
          if (!IF_STALL) begin
            fr_mem_nxt = NOP_INSTR;
            vld_nxt    = 1'b0;
          end
        end
      endcase
    end
  end

  // Stage boundary: PC/skid (p0) and fetch register (p1)
  always_ff @(posedge REG_CLOCK) begin
    if (REG_RESET) begin
      state_p0     <= FETCH;
      pc_p0        <= RESET_PC;
      disc_addr_p0 <= RESET_PC;
      skid_mem_p0  <= NOP_INSTR;
      skid_pc_p0   <= 32'd0;
      skid_pc_4_p0 <= 32'd0;
      skid_vld_p0  <= 1'b0;
      fr_mem_p1    <= NOP_INSTR;
      fr_pc_p1     <= 32'd0;
      fr_pc_4_p1   <= 32'd0;
      vld_p1       <= 1'b0;
    end else begin
      state_p0     <= state_nxt;
      pc_p0        <= pc_nxt;
      disc_addr_p0 <= disc_addr_nxt;
      skid_mem_p0  <= skid_mem_nxt;
      skid_pc_p0   <= skid_pc_nxt;
      skid_pc_4_p0 <= skid_pc_4_nxt;
      skid_vld_p0  <= skid_vld_nxt;
      fr_mem_p1    <= fr_mem_nxt;
      fr_pc_p1     <= fr_pc_nxt;
      fr_pc_4_p1   <= fr_pc_4_nxt;
      vld_p1       <= vld_nxt;
    end
  end

  assign FR_MEM   = fr_mem_p1;
  assign FR_PC    = fr_pc_p1;
  assign FR_PC_4  = fr_pc_4_p1;
  assign FR_VALID = vld_p1;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios followed by random traffic, all checked
// against a transaction-level model (outstanding request, drop flag, pending queue).
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        REG_CLOCK;
  logic        REG_RESET;
  logic        IF_STALL;
  logic [1:0]  PC_SOURCE;
  logic [31:0] JALR_TARGET;
  logic [31:0] BRANCH_TARGET;
  logic [31:0] JAL_TARGET;
  logic [31:0] IMEM_ADDR;
  logic        IMEM_REQ;
  logic        IMEM_ACK;
  logic [31:0] IMEM_DATA;
  logic [31:0] FR_MEM;
  logic [31:0] FR_PC;
  logic [31:0] FR_PC_4;
  logic        FR_VALID;

  fetch_stage dut (
    .REG_CLOCK    (REG_CLOCK),
    .REG_RESET    (REG_RESET),
    .IF_STALL     (IF_STALL),
    .PC_SOURCE    (PC_SOURCE),
    .JALR_TARGET  (JALR_TARGET),
    .BRANCH_TARGET(BRANCH_TARGET),
    .JAL_TARGET   (JAL_TARGET),
    .IMEM_ADDR    (IMEM_ADDR),
    .IMEM_REQ     (IMEM_REQ),
    .IMEM_ACK     (IMEM_ACK),
    .IMEM_DATA    (IMEM_DATA),
    .FR_MEM       (FR_MEM),
    .FR_PC        (FR_PC),
    .FR_PC_4      (FR_PC_4),
    .FR_VALID     (FR_VALID)
  );

  initial begin
    REG_CLOCK = 1'b0;
    forever #5 REG_CLOCK = ~REG_CLOCK;
  end

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    logic [31:0] ins;
    logic [31:0] pc;
    logic [31:0] pc4;
  } ent_t;

  // Reference model: next PC, address of a request whose reply must be thrown away,
  // and a queue of instructions fetched while decode was stalled.
  logic [31:0] m_pc;
  logic [31:0] m_drop_addr;
  bit          m_drop;
  ent_t        pend_q[$];
  logic [31:0] e_mem, e_pc, e_pc4;
  logic        e_vld;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic bubble();
    e_mem = NOP;
    e_vld = 1'b0;
  endtask

  task automatic step(input logic rst, input logic stall, input logic [1:0] src,
                      input logic ack, input logic [31:0] data);
    bit          waiting;
    bit          req;
    bit          got;
    logic [31:0] tgt;
    ent_t        e;
    REG_RESET = rst;
    IF_STALL  = stall;
    PC_SOURCE = src;
    IMEM_ACK  = ack;
    IMEM_DATA = data;
    #1;
    waiting = (pend_q.size() != 0);
    req     = !rst && !waiting;
    chk("imem_req", {31'd0, IMEM_REQ}, {31'd0, req});
    if (req) chk("imem_addr", IMEM_ADDR, m_drop ? m_drop_addr : m_pc);
    @(posedge REG_CLOCK);
    #1;
    got = req && ack;
    tgt = (src == 2'd1) ? JALR_TARGET : (src == 2'd2) ? BRANCH_TARGET : JAL_TARGET;
    if (rst) begin
      m_pc   = 32'h0;
      m_drop = 1'b0;
      pend_q.delete();
      e_mem = NOP; e_pc = 32'h0; e_pc4 = 32'h0; e_vld = 1'b0;
    end else if (src != 2'd0) begin
      bubble();
      if (!m_drop && !waiting && !got) begin
        m_drop      = 1'b1;
        m_drop_addr = m_pc;
      end
      pend_q.delete();
      m_pc = tgt;
    end else if (waiting) begin
      if (!stall) begin
        e = pend_q.pop_front();
        e_mem = e.ins; e_pc = e.pc; e_pc4 = e.pc4; e_vld = 1'b1;
      end
    end else if (m_drop) begin
      if (got) m_drop = 1'b0;
      if (!stall) bubble();
    end else if (got) begin
      if (stall) begin
        e.ins = data; e.pc = m_pc; e.pc4 = m_pc + 32'd4;
        pend_q.push_back(e);
      end else begin
        e_mem = data; e_pc = m_pc; e_pc4 = m_pc + 32'd4; e_vld = 1'b1;
      end
      m_pc = m_pc + 32'd4;
    end else if (!stall) begin
      bubble();
    end
    chk("fr_mem", FR_MEM, e_mem);
    chk("fr_pc", FR_PC, e_pc);
    chk("fr_pc_4", FR_PC_4, e_pc4);
    chk("fr_valid", {31'd0, FR_VALID}, {31'd0, e_vld});
  endtask

  initial begin
    m_pc = 32'h0; m_drop_addr = 32'h0; m_drop = 1'b0;
    e_mem = NOP; e_pc = 32'h0; e_pc4 = 32'h0; e_vld = 1'b0;
    JALR_TARGET = 32'h0; BRANCH_TARGET = 32'h0; JAL_TARGET = 32'h0;

    // Reset then zero-wait run
    step(1, 0, 0, 1, 32'h0);
    step(1, 0, 0, 1, 32'h0);
    chk("rst_fr_mem", FR_MEM, 32'h13);
    chk("rst_fr_valid", {31'd0, FR_VALID}, 32'd0);
    step(0, 0, 0, 1, 32'h11);
    chk("run0_pc", FR_PC, 32'h0);
    step(0, 0, 0, 1, 32'h22);
    chk("run1_mem", FR_MEM, 32'h22);
    step(0, 0, 0, 1, 32'h33);
    chk("run2_pc4", FR_PC_4, 32'd12);

    // Wait states
    step(1, 0, 0, 0, 32'h0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 32'h0);
    chk("wait_addr", IMEM_ADDR, 32'h0);
    step(0, 0, 0, 1, 32'h55);
    chk("wait_data", FR_MEM, 32'h55);
    chk("wait_next_addr", IMEM_ADDR, 32'h4);

    // Stall with ACK at PC 8
    step(0, 0, 0, 1, 32'h44);
    step(0, 1, 0, 1, 32'hAA);
    chk("stall_hold", FR_MEM, 32'h44);
    step(0, 1, 0, 0, 32'h0);
    step(0, 0, 0, 0, 32'h0);
    chk("release_mem", FR_MEM, 32'hAA);
    chk("release_pc", FR_PC, 32'h8);
    chk("release_next_addr", IMEM_ADDR, 32'hC);

    // Branch during outstanding request
    step(0, 0, 0, 1, 32'h66);
    BRANCH_TARGET = 32'h100;
    step(0, 0, 2, 0, 32'h0);
    step(0, 0, 0, 0, 32'h0);
    chk("discard_addr", IMEM_ADDR, 32'h10);
    step(0, 0, 0, 1, 32'h99);
    chk("discard_drop", {31'd0, FR_VALID}, 32'd0);
    chk("branch_addr", IMEM_ADDR, 32'h100);
    step(0, 0, 0, 1, 32'h77);

    // Redirect, stall and ACK together
    JAL_TARGET = 32'h40;
    step(0, 1, 3, 1, 32'h88);
    chk("jal_bubble", FR_MEM, 32'h13);
    chk("jal_addr", IMEM_ADDR, 32'h40);
    step(0, 0, 0, 1, 32'h3);

    // PC wrap, then reset with a request pending
    JALR_TARGET = 32'hFFFF_FFFC;
    step(0, 0, 1, 1, 32'h0);
    step(0, 0, 0, 1, 32'hEE);
    chk("wrap_pc4", FR_PC_4, 32'h0);
    chk("wrap_addr", IMEM_ADDR, 32'h0);
    step(0, 0, 0, 0, 32'h0);
    step(1, 0, 0, 1, 32'hBAD);
    chk("rst_mid_req", {31'd0, IMEM_REQ}, 32'd0);
    step(0, 0, 0, 1, 32'h12);
    chk("resume_pc", FR_PC, 32'h0);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      logic [1:0] src;
      src = ($urandom_range(0, 9) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
      JALR_TARGET   = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
      BRANCH_TARGET = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
      JAL_TARGET    = $urandom;
      step(($urandom_range(0, 99) == 0), ($urandom_range(0, 9) < 3), src,
           ($urandom_range(0, 9) < 6), $urandom);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
